// File: rtl/spi_flash_pkg.sv
// Shared constants and FSM encoding for the N25Q SPI flash reader.
package spi_flash_pkg;

    localparam logic [7:0]  CMD_READ               = 8'h03;
    localparam int unsigned CLK_DIV_DEFAULT        = 2;
    localparam int unsigned CS_IDLE_CYCLES_DEFAULT = 4;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StData,
        StDesel
    } state_e;

endpackage

// File: rtl/spi_sck_gen.sv
// Mode-0 SCK generator: half-period counter, SCK register and edge strobes.
// Strobes fire in the cycle before SCK changes, so users act on the same clk edge.
module spi_sck_gen #(
    parameter int unsigned ClkDiv = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    input  logic pause_i,
    output logic sck_o,
    output logic rise_tick_o,
    output logic fall_tick_o
);

    localparam int unsigned     CntW    = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ClkDiv - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sck_q, sck_d;
    logic            at_edge;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    // A paused rising edge parks the counter at its terminal value with SCK low.
    always_comb begin
        at_edge     = run_i && (cnt_q == CntLast);
        rise_tick_o = at_edge && !sck_q && !pause_i;
        fall_tick_o = at_edge && sck_q;
    end

    always_comb begin
        cnt_d = cnt_q;
        sck_d = sck_q;
        if (!run_i) begin
            cnt_d = '0;
            sck_d = 1'b0;
        end else if (rise_tick_o || fall_tick_o) begin
            cnt_d = '0;
            sck_d = !sck_q;
        end else if (!at_edge) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    assign sck_o = sck_q;

endmodule

// File: rtl/spi_flash_reader.sv
// SPI mode-0 READ (0x03) master for N25Q flash with a valid/ready byte stream out.
module spi_flash_reader
    import spi_flash_pkg::*;
#(
    parameter int unsigned CLK_DIV        = CLK_DIV_DEFAULT,
    parameter int unsigned CS_IDLE_CYCLES = CS_IDLE_CYCLES_DEFAULT,
    parameter int unsigned ADDR_WIDTH     = 24,
    parameter int unsigned LEN_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    output logic [7:0]            dout_data,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  busy,
    output logic                  spi_cs_n,
    output logic                  spi_sck,
    output logic                  spi_mosi,
    input  logic                  spi_miso,
    output logic                  spi_wp_n,
    output logic                  spi_hold_n
);

    localparam int unsigned        TxW       = ADDR_WIDTH + 8;
    localparam int unsigned        BitCntW   = $clog2(ADDR_WIDTH + 8);
    localparam int unsigned        DeselW    = $clog2(CLK_DIV + CS_IDLE_CYCLES + 1);
    localparam logic [BitCntW-1:0] ByteLast  = BitCntW'(7);
    localparam logic [BitCntW-1:0] AddrLast  = BitCntW'(ADDR_WIDTH - 1);
    localparam logic [DeselW-1:0]  CsRiseCnt = DeselW'(CLK_DIV - 1);
    localparam logic [DeselW-1:0]  DeselLast = DeselW'(CLK_DIV + CS_IDLE_CYCLES - 1);

    state_e               state_q, state_d;
    logic [TxW-1:0]       tx_sr_q, tx_sr_d;
    logic [7:0]           rx_sr_q, rx_sr_d;
    logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
    logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DeselW-1:0]    desel_cnt_q, desel_cnt_d;
    logic                 cs_n_q, cs_n_d;
    logic                 pending_q, pending_d;
    logic                 dout_valid_q, dout_valid_d;
    logic [7:0]           dout_data_q, dout_data_d;

    logic sck_run, sck_pause, rise_tick, fall_tick;

    spi_sck_gen #(
        .ClkDiv(CLK_DIV)
    ) u_sck_gen (
        .clk_i      (clk),
        .rst_ni     (reset_n),
        .run_i      (sck_run),
        .pause_i    (sck_pause),
        .sck_o      (spi_sck),
        .rise_tick_o(rise_tick),
        .fall_tick_o(fall_tick)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            tx_sr_q      <= '0;
            rx_sr_q      <= '0;
            remaining_q  <= '0;
            bit_cnt_q    <= '0;
            desel_cnt_q  <= '0;
            cs_n_q       <= 1'b1;
            pending_q    <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            tx_sr_q      <= tx_sr_d;
            rx_sr_q      <= rx_sr_d;
            remaining_q  <= remaining_d;
            bit_cnt_q    <= bit_cnt_d;
            desel_cnt_q  <= desel_cnt_d;
            cs_n_q       <= cs_n_d;
            pending_q    <= pending_d;
            dout_valid_q <= dout_valid_d;
            dout_data_q  <= dout_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tx_sr_d      = tx_sr_q;
        rx_sr_d      = rx_sr_q;
        remaining_d  = remaining_q;
        bit_cnt_d    = bit_cnt_q;
        desel_cnt_d  = desel_cnt_q;
        cs_n_d       = cs_n_q;
        pending_d    = 1'b0;
        dout_valid_d = dout_valid_q;
        dout_data_d  = dout_data_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready) begin
                    tx_sr_d     = {CMD_READ, req_addr};
                    remaining_d = req_len;
                    bit_cnt_d   = '0;
                    if (req_len != '0) begin
                        state_d = StCmd;
                        cs_n_d  = 1'b0;
                    end
                end
            end
            StCmd: begin
                if (fall_tick) begin
                    tx_sr_d = {tx_sr_q[TxW-2:0], 1'b0};
                    if (bit_cnt_q == ByteLast) begin
                        bit_cnt_d = '0;
                        state_d   = StAddr;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitCntW'(1);
                    end
                end
            end
            StAddr: begin
                if (fall_tick) begin
                    tx_sr_d = {tx_sr_q[TxW-2:0], 1'b0};
                    if (bit_cnt_q == AddrLast) begin
                        bit_cnt_d = '0;
                        state_d   = StData;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitCntW'(1);
                    end
                end
            end
            StData: begin
                if (rise_tick) begin
                    rx_sr_d = {rx_sr_q[6:0], spi_miso};
                    if (bit_cnt_q == ByteLast) begin
                        bit_cnt_d   = '0;
                        pending_d   = 1'b1;
                        remaining_d = remaining_q - LEN_WIDTH'(1);
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitCntW'(1);
                    end
                end
                // SCK stops after the last fall; DESEL then times tCHSH before CS rises.
                if (fall_tick && (remaining_q == '0)) begin
                    state_d     = StDesel;
                    desel_cnt_d = '0;
                end
            end
            StDesel: begin
                desel_cnt_d = desel_cnt_q + DeselW'(1);
                if (desel_cnt_q == CsRiseCnt) begin
                    cs_n_d = 1'b1;
                end
                if (desel_cnt_q == DeselLast) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (pending_q) begin
            dout_valid_d = 1'b1;
            dout_data_d  = rx_sr_q;
        end else if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    always_comb begin
        sck_run   = (state_q == StCmd) || (state_q == StAddr) || (state_q == StData);
        // Hold the 8th rising edge while the previous byte is still unconsumed.
        sck_pause = (state_q == StData) && (bit_cnt_q == ByteLast) && dout_valid_q &&
                    !dout_ready;
        req_ready = reset_n && (state_q == StIdle) && !dout_valid_q;
        busy      = (state_q != StIdle);
        spi_mosi  = ((state_q == StCmd) || (state_q == StAddr)) && tx_sr_q[TxW-1];
    end

    assign spi_cs_n   = cs_n_q;
    assign dout_valid = dout_valid_q;
    assign dout_data  = dout_data_q;
    assign spi_wp_n   = 1'b1;
    assign spi_hold_n = 1'b1;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader with a behavioural N25Q READ responder.
module tb_spi_flash_reader;

    localparam int PER = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic [15:0] req_len;
    logic [7:0]  dout_data;
    logic        dout_valid;
    logic        dout_ready;
    logic        busy;
    logic        spi_cs_n, spi_sck, spi_mosi, spi_wp_n, spi_hold_n;
    logic        spi_miso = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    spi_flash_reader #(
        .CLK_DIV       (2),
        .CS_IDLE_CYCLES(4),
        .ADDR_WIDTH    (24),
        .LEN_WIDTH     (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .dout_data (dout_data),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .busy      (busy),
        .spi_cs_n  (spi_cs_n),
        .spi_sck   (spi_sck),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .spi_wp_n  (spi_wp_n),
        .spi_hold_n(spi_hold_n)
    );

    always #(PER / 2) clk = ~clk;

    // Flash contents and bus monitors; each variable has a single writer.
    logic [7:0]  mem [0:511];
    logic [31:0] fl_in = '0;
    int          fl_bits = 0, fl_seen = 0;
    int          rise_cnt = 0, cs_fall_cnt = 0, vr_cnt = 0;
    int          stab_err = 0, rdy_busy_err = 0;
    time         last_rise_t = 0, last_fall_t = 0, first_rise_t = 0;
    time         cs_fall_t = 0, cs_rise_t = 0, last_gap = 0, vr_t = 0;
    logic [7:0]  got[$];
    time         vr_times[$];
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;

    always @(posedge spi_sck) begin
        if (cs_fall_cnt != fl_seen) begin
            fl_seen      = cs_fall_cnt;
            fl_bits      = 0;
            first_rise_t = $time;
        end
        if (!spi_cs_n) begin
            if (fl_bits < 32) fl_in = {fl_in[30:0], spi_mosi};
            fl_bits++;
        end
        rise_cnt++;
        last_rise_t = $time;
    end

    always @(negedge spi_sck) begin
        int         idx;
        logic [7:0] b;
        last_fall_t = $time;
        if (!spi_cs_n && fl_bits >= 32) begin
            idx      = fl_bits - 32;
            b        = mem[(int'(fl_in[8:0]) + idx / 8) % 512];
            spi_miso = b[7 - idx % 8];
        end
    end

    always @(negedge spi_cs_n) begin
        cs_fall_cnt++;
        cs_fall_t = $time;
        last_gap  = $time - cs_rise_t;
    end

    always @(posedge spi_cs_n) cs_rise_t = $time;

    always @(posedge dout_valid) begin
        vr_cnt++;
        vr_t = $time;
        vr_times.push_back($time);
    end

    always @(posedge clk) begin
        if (reset_n) begin
            if (dout_valid && dout_ready) got.push_back(dout_data);
            if (prev_stall && (!dout_valid || dout_data != prev_data)) stab_err++;
            if (busy && req_ready) rdy_busy_err++;
            prev_stall = dout_valid && !dout_ready;
            prev_data  = dout_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic send_req(input logic [23:0] a, input logic [15:0] l);
        int n = 0;
        req_addr  = a;
        req_len   = l;
        req_valid = 1'b1;
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("req_accept_in_time", 32'(n < 2000), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((busy || dout_valid) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_eq("done_in_time", 32'(n < 5000), 32'd1);
    endtask

    initial begin
        #(PER * 100000);
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n, gb, vb, rc0, rc1, cf0, vc0;

        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        mem[9'h100] = 8'hA5;
        mem[9'h101] = 8'h3C;
        mem[9'h102] = 8'h0F;
        mem[9'h103] = 8'h96;

        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_len    = '0;
        dout_ready = 1'b1;

        // Reset idle
        repeat (5) @(negedge clk);
        check_eq("rst_cs_n", 32'(spi_cs_n), 32'd1);
        check_eq("rst_sck", 32'(spi_sck), 32'd0);
        check_eq("rst_mosi", 32'(spi_mosi), 32'd0);
        check_eq("rst_dout_valid", 32'(dout_valid), 32'd0);
        check_eq("rst_dout_data", 32'(dout_data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_wp_hold", {30'd0, spi_wp_n, spi_hold_n}, 32'd3);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_req_ready", 32'(req_ready), 32'd1);

        // Basic read of three bytes
        gb  = got.size();
        vb  = vr_times.size();
        rc0 = rise_cnt;
        send_req(24'h000100, 16'd3);
        check_eq("acc_busy", 32'(busy), 32'd1);
        check_eq("acc_cs_low", 32'(spi_cs_n), 32'd0);
        wait_done();
        check_eq("basic_mosi_hdr", fl_in, 32'h03000100);
        check_eq("basic_nbytes", 32'(got.size() - gb), 32'd3);
        check_eq("basic_b0", 32'(got[gb]), 32'hA5);
        check_eq("basic_b1", 32'(got[gb+1]), 32'h3C);
        check_eq("basic_b2", 32'(got[gb+2]), 32'h0F);
        check_eq("basic_sck_rises", 32'(rise_cnt - rc0), 32'd56);
        check_eq("basic_tslch", 32'(first_rise_t - cs_fall_t), 32'(2 * PER));
        check_eq("basic_tchsh", 32'(cs_rise_t - last_fall_t), 32'(2 * PER));
        check_eq("basic_valid_lat", 32'(vr_t - last_rise_t), 32'(PER));
        check_eq("basic_byte_period", 32'(vr_times[vb+1] - vr_times[vb]), 32'(32 * PER));
        check_eq("basic_byte_period2", 32'(vr_times[vb+2] - vr_times[vb+1]), 32'(32 * PER));

        // Backpressure: first byte held for 200 clk
        gb         = got.size();
        rc0        = rise_cnt;
        dout_ready = 1'b0;
        send_req(24'h000100, 16'd3);
        n = 0;
        while (!dout_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("bp_first_valid", 32'(n < 2000), 32'd1);
        repeat (100) @(negedge clk);
        rc1 = rise_cnt;
        repeat (100) @(negedge clk);
        check_eq("bp_sck_frozen", 32'(rise_cnt - rc1), 32'd0);
        check_eq("bp_sck_low", 32'(spi_sck), 32'd0);
        check_eq("bp_frozen_at_edge", 32'(rise_cnt - rc0), 32'd47);
        check_eq("bp_held_data", 32'(dout_data), 32'hA5);
        dout_ready = 1'b1;
        wait_done();
        check_eq("bp_nbytes", 32'(got.size() - gb), 32'd3);
        check_eq("bp_b0", 32'(got[gb]), 32'hA5);
        check_eq("bp_b1", 32'(got[gb+1]), 32'h3C);
        check_eq("bp_b2", 32'(got[gb+2]), 32'h0F);
        check_eq("bp_sck_rises", 32'(rise_cnt - rc0), 32'd56);
        check_eq("bp_data_stable", 32'(stab_err), 32'd0);

        // Zero length
        cf0 = cs_fall_cnt;
        vc0 = vr_cnt;
        send_req(24'h000100, 16'd0);
        check_eq("zl_ready_again", 32'(req_ready), 32'd1);
        check_eq("zl_not_busy", 32'(busy), 32'd0);
        repeat (20) @(negedge clk);
        check_eq("zl_no_cs", 32'(cs_fall_cnt - cf0), 32'd0);
        check_eq("zl_no_valid", 32'(vr_cnt - vc0), 32'd0);

        // Back-to-back single-byte reads
        gb = got.size();
        send_req(24'h000100, 16'd1);
        send_req(24'h000102, 16'd1);
        check_eq("b2b_cs_gap", 32'(last_gap >= 4 * PER), 32'd1);
        wait_done();
        check_eq("b2b_nbytes", 32'(got.size() - gb), 32'd2);
        check_eq("b2b_b0", 32'(got[gb]), 32'hA5);
        check_eq("b2b_b1", 32'(got[gb+1]), 32'h0F);
        check_eq("b2b_ready_low_busy", 32'(rdy_busy_err), 32'd0);

        // Reset during the second byte of a four-byte read
        rc0 = rise_cnt;
        send_req(24'h000100, 16'd4);
        n = 0;
        while ((rise_cnt - rc0) < 44 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("mid_reach_byte2", 32'(n < 2000), 32'd1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_rst_cs_n", 32'(spi_cs_n), 32'd1);
        check_eq("mid_rst_sck", 32'(spi_sck), 32'd0);
        check_eq("mid_rst_valid", 32'(dout_valid), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        gb = got.size();
        send_req(24'h000101, 16'd2);
        wait_done();
        check_eq("mid_new_nbytes", 32'(got.size() - gb), 32'd2);
        check_eq("mid_new_b0", 32'(got[gb]), 32'h3C);
        check_eq("mid_new_b1", 32'(got[gb+1]), 32'h0F);
        check_eq("mid_new_hdr", fl_in, 32'h03000101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
